// File: rtl/snappy_pkg.sv
// Shared constants, widths and state encoding for the Snappy token slicer and
// the parsers around it.
package snappy_pkg;

    // Largest literal slice, set by the 128-bit parser_lit data path.
    localparam int unsigned LIT_MAX = 16;
    // Largest copy slice, set by the 6-bit parser_copy length.
    localparam int unsigned CPY_MAX = 64;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned DATA_W  = 128;
    // Slice byte count: 1..CPY_MAX fits in 7 bits.
    localparam int unsigned SLICE_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIT  = 2'd1,
        CPY  = 2'd2
    } state_t;

endpackage

// File: rtl/slice_len_calc.sv
// Combinational slice sizer: len = min(rem+1, cap, off), plus a flag that this
// slice finishes the token. rem is the remaining byte count minus 1.
// Ports:
//   rem     remaining bytes minus 1
//   cap     per-slice byte cap (LIT_MAX or CPY_MAX)
//   off     copy offset; 0xFFFF for literals so it never limits
//   len     bytes in this slice (1..cap)
//   is_last this slice consumes everything that is left
module slice_len_calc
    import snappy_pkg::*;
(
    input  logic [LEN_W-1:0]   rem,
    input  logic [SLICE_W-1:0] cap,
    input  logic [LEN_W-1:0]   off,
    output logic [SLICE_W-1:0] len,
    output logic               is_last
);

    localparam int unsigned SW = LEN_W + 1;

    logic [SW-1:0] total;
    logic [SW-1:0] m_cap;
    logic [SW-1:0] m_off;

    // 17-bit compare so a 65536-byte remainder does not wrap to 0.
    always_comb begin
        total   = SW'(rem) + SW'(1);
        m_cap   = (total < SW'(cap)) ? total : SW'(cap);
        m_off   = (m_cap < SW'(off)) ? m_cap : SW'(off);
        len     = SLICE_W'(m_off);
        is_last = (m_off == total);
    end

endmodule

// File: rtl/token_slicer.sv
// Slices decoded Snappy tokens into parser_lit / parser_copy commands and
// tracks the running history-buffer address of each slice.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cmd_*                  token command handshake (literal or copy)
//   lit_data/valid/ready   128-bit literal beat handshake
//   stall                  downstream arbiter busy; no slice may issue
//   lit_out_*              literal slice to parser_lit (one-cycle strobe)
//   cpy_out_*              copy slice to parser_copy (one-cycle strobe)
//   err                    sticky: a copy with offset 0 was received
module token_slicer
    import snappy_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_copy,
    input  logic [LEN_W-1:0]     cmd_length,
    input  logic [LEN_W-1:0]     cmd_offset,
    input  logic [ADDR_W-1:0]    cmd_address,
    input  logic [DATA_W-1:0]    lit_data,
    input  logic                 lit_valid,
    output logic                 lit_ready,
    input  logic                 stall,
    output logic [DATA_W-1:0]    lit_out_data,
    output logic [3:0]           lit_out_length,
    output logic [ADDR_W-1:0]    lit_out_address,
    output logic                 lit_out_valid,
    output logic [5:0]           cpy_out_length,
    output logic [ADDR_W-1:0]    cpy_out_address,
    output logic [LEN_W-1:0]     cpy_out_offset,
    output logic                 cpy_out_valid,
    output logic                 err
);

    state_t state;
    state_t state_nx;

    logic [LEN_W-1:0]   rem_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   off_q;

    logic               cmd_fire;
    logic               lit_fire;
    logic               cpy_issue;
    logic               off_zero;

    logic [SLICE_W-1:0] calc_cap;
    logic [LEN_W-1:0]   calc_off;
    logic [SLICE_W-1:0] slice_n;
    logic               slice_last;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign lit_fire = lit_valid & lit_ready;
    assign off_zero = (cmd_offset == '0);

    // One sizer shared by both paths; literals are never offset-limited.
    always_comb begin
        calc_cap = SLICE_W'(CPY_MAX);
        calc_off = off_q;
        if (state == LIT) begin
            calc_cap = SLICE_W'(LIT_MAX);
            calc_off = '1;
        end
    end

    slice_len_calc u_calc (
        .rem     (rem_q),
        .cap     (calc_cap),
        .off     (calc_off),
        .len     (slice_n),
        .is_last (slice_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a zero-offset copy is dropped and leaves us in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_fire && !cmd_is_copy) begin
                    state_nx = LIT;
                end else if (cmd_fire && !off_zero) begin
                    state_nx = CPY;
                end
            end
            LIT: begin
                if (lit_fire && slice_last) begin
                    state_nx = IDLE;
                end
            end
            CPY: begin
                if (cpy_issue && slice_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Handshake / issue controls, all gated by stall.
    always_comb begin
        cmd_ready = 1'b0;
        lit_ready = 1'b0;
        cpy_issue = 1'b0;
        case (state)
            IDLE:    cmd_ready = !stall && !rst;
            LIT:     lit_ready = !stall;
            CPY:     cpy_issue = !stall;
            default: ;
        endcase
    end

    // Token context and registered slice outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q           <= '0;
            addr_q          <= '0;
            off_q           <= '0;
            lit_out_data    <= '0;
            lit_out_length  <= '0;
            lit_out_address <= '0;
            lit_out_valid   <= 1'b0;
            cpy_out_length  <= '0;
            cpy_out_address <= '0;
            cpy_out_offset  <= '0;
            cpy_out_valid   <= 1'b0;
            err             <= 1'b0;
        end else begin
            lit_out_valid <= 1'b0;
            cpy_out_valid <= 1'b0;

            if (cmd_fire) begin
                if (cmd_is_copy && off_zero) begin
                    err <= 1'b1;
                end else begin
                    rem_q  <= cmd_length;
                    addr_q <= cmd_address;
                    off_q  <= cmd_offset;
                end
            end

            if (lit_fire) begin
                lit_out_valid   <= 1'b1;
                lit_out_data    <= lit_data;
                lit_out_length  <= 4'(slice_n - SLICE_W'(1));
                lit_out_address <= addr_q;
                addr_q          <= addr_q + ADDR_W'(slice_n);
                rem_q           <= rem_q - LEN_W'(slice_n);
            end

            if (cpy_issue) begin
                cpy_out_valid   <= 1'b1;
                cpy_out_length  <= 6'(slice_n - SLICE_W'(1));
                cpy_out_address <= addr_q;
                cpy_out_offset  <= off_q;
                addr_q          <= addr_q + ADDR_W'(slice_n);
                rem_q           <= rem_q - LEN_W'(slice_n);
            end
        end
    end

endmodule

// File: tb/tb_token_slicer.sv
// Directed bench for token_slicer: literal, copy, overlapping copy, stall,
// address wrap, zero-offset error and asynchronous reset.
module tb_token_slicer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_is_copy;
    logic [15:0]  cmd_length;
    logic [15:0]  cmd_offset;
    logic [15:0]  cmd_address;
    logic [127:0] lit_data;
    logic         lit_valid;
    logic         lit_ready;
    logic         stall;
    logic [127:0] lit_out_data;
    logic [3:0]   lit_out_length;
    logic [15:0]  lit_out_address;
    logic         lit_out_valid;
    logic [5:0]   cpy_out_length;
    logic [15:0]  cpy_out_address;
    logic [15:0]  cpy_out_offset;
    logic         cpy_out_valid;
    logic         err;

    token_slicer dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_is_copy     (cmd_is_copy),
        .cmd_length      (cmd_length),
        .cmd_offset      (cmd_offset),
        .cmd_address     (cmd_address),
        .lit_data        (lit_data),
        .lit_valid       (lit_valid),
        .lit_ready       (lit_ready),
        .stall           (stall),
        .lit_out_data    (lit_out_data),
        .lit_out_length  (lit_out_length),
        .lit_out_address (lit_out_address),
        .lit_out_valid   (lit_out_valid),
        .cpy_out_length  (cpy_out_length),
        .cpy_out_address (cpy_out_address),
        .cpy_out_offset  (cpy_out_offset),
        .cpy_out_valid   (cpy_out_valid),
        .err             (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int both_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed slices, sampled mid-cycle.
    logic [3:0]   lq_len[$];
    logic [15:0]  lq_addr[$];
    logic [127:0] lq_data[$];
    int           lq_cyc[$];
    logic [5:0]   cq_len[$];
    logic [15:0]  cq_addr[$];
    logic [15:0]  cq_off[$];
    int           cq_cyc[$];

    always @(negedge clk) begin
        if (lit_out_valid) begin
            lq_len.push_back(lit_out_length);
            lq_addr.push_back(lit_out_address);
            lq_data.push_back(lit_out_data);
            lq_cyc.push_back(cyc);
        end
        if (cpy_out_valid) begin
            cq_len.push_back(cpy_out_length);
            cq_addr.push_back(cpy_out_address);
            cq_off.push_back(cpy_out_offset);
            cq_cyc.push_back(cyc);
        end
        if (lit_out_valid && cpy_out_valid) both_cnt++;
    end

    // Expected slices for the current scenario.
    logic [15:0] exp_len[8];
    logic [15:0] exp_addr[8];
    int          exp_dcyc[8];

    task automatic clear_q();
        lq_len.delete(); lq_addr.delete(); lq_data.delete(); lq_cyc.delete();
        cq_len.delete(); cq_addr.delete(); cq_off.delete(); cq_cyc.delete();
    endtask

    function automatic logic [127:0] beat(input int i);
        logic [7:0] b;
        b = 8'(8'h11 * (i + 1) + 8'h05);
        return {16{b}};
    endfunction

    // Present one command; acc = cycle count sampled just after acceptance.
    task automatic send_cmd(input logic c, input logic [15:0] len, input logic [15:0] off,
                            input logic [15:0] addr, output int acc, output bit ok);
        ok  = 1'b0;
        acc = 0;
        @(negedge clk);
        cmd_is_copy = c; cmd_length = len; cmd_offset = off; cmd_address = addr;
        cmd_valid = 1'b1;
        for (int b = 0; b < 20 && !ok; b++) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        acc = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept: actual=not accepted required=accepted within 20 cycles");
        end
    endtask

    task automatic run_lit(input string name, input logic [15:0] len, input logic [15:0] addr,
                           input int nb);
        int  acc;
        bit  ok;
        int  bcyc[8];
        bit  got;
        clear_q();
        send_cmd(1'b0, len, 16'h0000, addr, acc, ok);
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_in_lit: actual=%b required=0", name, cmd_ready);
        end
        for (int i = 0; i < nb; i++) begin
            lit_data  = beat(i);
            lit_valid = 1'b1;
            got = 1'b0;
            for (int b = 0; b < 20 && !got; b++) begin
                #1;
                if (lit_ready) begin
                    @(posedge clk);
                    got = 1'b1;
                end
                @(negedge clk);
            end
            bcyc[i] = cyc;
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL %s_beat%0d: actual=not taken required=taken", name, i);
            end
        end
        lit_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after: actual=%b required=1", name, cmd_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (lq_len.size() != nb) begin
            errors++;
            $display("FAIL %s_count: actual=%0d required=%0d", name, lq_len.size(), nb);
        end
        for (int i = 0; i < nb && i < lq_len.size(); i++) begin
            checks += 4;
            if (lq_len[i] !== 4'(exp_len[i])) begin
                errors++;
                $display("FAIL %s_len%0d: actual=%0d required=%0d", name, i, lq_len[i], exp_len[i]);
            end
            if (lq_addr[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL %s_addr%0d: actual=%h required=%h", name, i, lq_addr[i], exp_addr[i]);
            end
            if (lq_data[i] !== beat(i)) begin
                errors++;
                $display("FAIL %s_data%0d: actual=%h required=%h", name, i, lq_data[i], beat(i));
            end
            if (lq_cyc[i] != bcyc[i]) begin
                errors++;
                $display("FAIL %s_cyc%0d: actual=%0d required=%0d", name, i, lq_cyc[i], bcyc[i]);
            end
        end
    endtask

    // Copy run; stall_at >= 0 raises stall for 3 cycles at acc+stall_at.
    task automatic run_cpy(input string name, input logic [15:0] len, input logic [15:0] off,
                           input logic [15:0] addr, input int n, input int stall_at);
        int acc;
        bit ok;
        clear_q();
        send_cmd(1'b1, len, off, addr, acc, ok);
        for (int k = 0; k < n + 10; k++) begin
            @(negedge clk);
            if (stall_at >= 0 && cyc == acc + stall_at)     stall = 1'b1;
            if (stall_at >= 0 && cyc == acc + stall_at + 3) stall = 1'b0;
        end
        stall = 1'b0;
        checks += 2;
        if (cq_len.size() != n) begin
            errors++;
            $display("FAIL %s_count: actual=%0d required=%0d", name, cq_len.size(), n);
        end
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL %s_both_valid: actual=%0d required=0", name, both_cnt);
        end
        for (int i = 0; i < n && i < cq_len.size(); i++) begin
            checks += 4;
            if (cq_len[i] !== 6'(exp_len[i])) begin
                errors++;
                $display("FAIL %s_len%0d: actual=%0d required=%0d", name, i, cq_len[i], exp_len[i]);
            end
            if (cq_addr[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL %s_addr%0d: actual=%h required=%h", name, i, cq_addr[i], exp_addr[i]);
            end
            if (cq_off[i] !== off) begin
                errors++;
                $display("FAIL %s_off%0d: actual=%h required=%h", name, i, cq_off[i], off);
            end
            if (cq_cyc[i] != acc + exp_dcyc[i]) begin
                errors++;
                $display("FAIL %s_cyc%0d: actual=%0d required=%0d", name, i, cq_cyc[i] - acc, exp_dcyc[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_is_copy = 1'b0; cmd_length = '0; cmd_offset = '0;
        cmd_address = '0; lit_data = '0; lit_valid = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready: actual=%b required=0", cmd_ready);
        end
        if (lit_out_valid !== 1'b0 || cpy_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: actual=%b%b required=00", lit_out_valid, cpy_out_valid);
        end
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: actual=%b required=0", err);
        end
        if (lit_out_data !== '0 || cpy_out_address !== '0 || lit_out_length !== '0) begin
            errors++; $display("FAIL reset_outputs: actual=nonzero required=0");
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: actual=%b required=1", cmd_ready);
        end
    endtask

    task automatic test_literal();
        exp_len[0] = 15; exp_addr[0] = 16'h0103;
        exp_len[1] = 15; exp_addr[1] = 16'h0113;
        exp_len[2] = 4;  exp_addr[2] = 16'h0123;
        run_lit("lit", 16'h0024, 16'h0103, 3);
    endtask

    task automatic test_copy();
        exp_len[0] = 63; exp_addr[0] = 16'h1000; exp_dcyc[0] = 1;
        exp_len[1] = 63; exp_addr[1] = 16'h1040; exp_dcyc[1] = 2;
        exp_len[2] = 21; exp_addr[2] = 16'h1080; exp_dcyc[2] = 3;
        run_cpy("copy", 16'h0095, 16'h0200, 16'h1000, 3, -1);
    endtask

    task automatic test_overlap();
        exp_len[0] = 2; exp_addr[0] = 16'h0050; exp_dcyc[0] = 1;
        exp_len[1] = 2; exp_addr[1] = 16'h0053; exp_dcyc[1] = 2;
        exp_len[2] = 2; exp_addr[2] = 16'h0056; exp_dcyc[2] = 3;
        exp_len[3] = 0; exp_addr[3] = 16'h0059; exp_dcyc[3] = 4;
        run_cpy("overlap", 16'h0009, 16'h0003, 16'h0050, 4, -1);
    endtask

    task automatic test_stall();
        exp_len[0] = 63; exp_addr[0] = 16'h2000; exp_dcyc[0] = 1;
        exp_len[1] = 63; exp_addr[1] = 16'h2040; exp_dcyc[1] = 5;
        exp_len[2] = 63; exp_addr[2] = 16'h2080; exp_dcyc[2] = 6;
        exp_len[3] = 63; exp_addr[3] = 16'h20C0; exp_dcyc[3] = 7;
        run_cpy("stall", 16'h00FF, 16'h0100, 16'h2000, 4, 1);
    endtask

    task automatic test_wrap();
        exp_len[0] = 15; exp_addr[0] = 16'hFFF8;
        exp_len[1] = 3;  exp_addr[1] = 16'h0008;
        run_lit("wrap", 16'h0013, 16'hFFF8, 2);
    endtask

    task automatic test_error();
        int acc;
        bit ok;
        clear_q();
        send_cmd(1'b1, 16'h0005, 16'h0000, 16'h0020, acc, ok);
        #1;
        checks += 2;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_set: actual=%b required=1", err);
        end
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL err_idle_ready: actual=%b required=1", cmd_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (cq_len.size() != 0 || lq_len.size() != 0) begin
            errors++; $display("FAIL err_no_slice: actual=%0d required=0", cq_len.size() + lq_len.size());
        end
        exp_len[0] = 0; exp_addr[0] = 16'h0010; exp_dcyc[0] = 1;
        run_cpy("after_err", 16'h0000, 16'h0001, 16'h0010, 1, -1);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: actual=%b required=1", err);
        end
    endtask

    task automatic test_async_reset();
        int acc;
        bit ok;
        send_cmd(1'b1, 16'h03FF, 16'h0400, 16'h0000, acc, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (cpy_out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre_valid: actual=%b required=1", cpy_out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (cpy_out_valid !== 1'b0 || lit_out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async_valids: actual=%b%b required=00", lit_out_valid, cpy_out_valid);
        end
        if (err !== 1'b0) begin
            errors++; $display("FAIL rst_async_err: actual=%b required=0", err);
        end
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rst_async_ready: actual=%b required=0", cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: actual=%b required=1", cmd_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (cq_len.size() != 0) begin
            errors++; $display("FAIL rst_no_resume: actual=%0d required=0", cq_len.size());
        end
    endtask

    initial begin
        test_reset();
        test_literal();
        test_copy();
        test_overlap();
        test_stall();
        test_wrap();
        test_error();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
